// File: rtl/text_term_pkg.sv
// Shared types and constants for the 70x30 terminal text writer.
//   state_t   : controller states
//   BS/LF/FF/CR/BLANK : ASCII codes interpreted by the controller
//   FIELD_W/FIELD_H and index widths, plus typed "last index" constants
package text_term_pkg;

    localparam int unsigned FIELD_W = 70;
    localparam int unsigned FIELD_H = 30;
    localparam int unsigned COL_W   = 7;
    localparam int unsigned ROW_W   = 5;
    localparam int unsigned ADDR_W  = ROW_W + COL_W;

    localparam logic [7:0] BS    = 8'h08;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] FF    = 8'h0C;
    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] BLANK = 8'h20;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(FIELD_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FIELD_H - 1);

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        IDLE   = 2'd1,
        WRITE  = 2'd2,
        SCROLL = 2'd3
    } state_t;

    // Row index increment, wrapping at FIELD_H.
    function automatic logic [ROW_W-1:0] row_inc(input logic [ROW_W-1:0] r);
        return (r == ROW_LAST) ? '0 : r + ROW_W'(1);
    endfunction

endpackage

// File: rtl/text_row_mapper.sv
// Maps a logical screen row to a physical RAM row: (top_row + row) mod FIELD_H.
//   top_row    : physical row currently shown at the top of the screen
//   row        : logical row, 0..FIELD_H-1
//   phys_row_c : physical row, combinational, always < FIELD_H
module text_row_mapper
    import text_term_pkg::*;
(
    input  logic [ROW_W-1:0] top_row,
    input  logic [ROW_W-1:0] row,
    output logic [ROW_W-1:0] phys_row_c
);

    localparam int unsigned SUM_W = ROW_W + 1;

    logic [SUM_W-1:0] sum_c;

    // Both operands are < FIELD_H, so one conditional subtract suffices.
    always_comb begin
        sum_c = {1'b0, top_row} + {1'b0, row};
        if (sum_c >= SUM_W'(FIELD_H)) begin
            phys_row_c = ROW_W'(sum_c - SUM_W'(FIELD_H));
        end else begin
            phys_row_c = sum_c[ROW_W-1:0];
        end
    end

endmodule

// File: rtl/text_term_ctrl.sv
// Terminal-style write controller for the 70x30 character text RAM.
//   clk, rst          : clock, asynchronous active-low reset
//   ch_valid/ch_data  : input byte stream; ch_ready high only in IDLE
//   wr_en/wr_addr/wr_data : text RAM write port, wr_addr = {phys_row, col}
//   cur_row/cur_col   : logical cursor position
//   top_row           : physical row displayed at the top (scroll base)
//   busy              : high whenever not IDLE
module text_term_ctrl
    import text_term_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ch_valid,
    input  logic [7:0]        ch_data,
    output logic              ch_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [ROW_W-1:0]  cur_row,
    output logic [COL_W-1:0]  cur_col,
    output logic [ROW_W-1:0]  top_row,
    output logic              busy
);

    state_t            state, nxt_state;
    logic              nxt_wr_en;
    logic [ADDR_W-1:0] nxt_wr_addr;
    logic [7:0]        nxt_wr_data;
    logic [ROW_W-1:0]  nxt_cur_row, nxt_top_row;
    logic [COL_W-1:0]  nxt_cur_col;
    logic [ROW_W-1:0]  clr_row, nxt_clr_row;
    logic [COL_W-1:0]  clr_col, nxt_clr_col;
    logic              scroll_pend, nxt_scroll_pend;
    logic [ROW_W-1:0]  phys_row_c;
    logic              accept_c, printable_c, newline_c;

    text_row_mapper u_row_mapper (
        .top_row    (top_row),
        .row        (cur_row),
        .phys_row_c (phys_row_c)
    );

    assign accept_c    = ch_valid && ch_ready;
    assign printable_c = (ch_data >= 8'h20) && (ch_data <= 8'h7E);

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= INIT;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= BLANK;
            cur_row     <= '0;
            cur_col     <= '0;
            top_row     <= '0;
            clr_row     <= '0;
            clr_col     <= '0;
            scroll_pend <= 1'b0;
            busy        <= 1'b1;
            ch_ready    <= 1'b0;
        end else begin
            state       <= nxt_state;
            wr_en       <= nxt_wr_en;
            wr_addr     <= nxt_wr_addr;
            wr_data     <= nxt_wr_data;
            cur_row     <= nxt_cur_row;
            cur_col     <= nxt_cur_col;
            top_row     <= nxt_top_row;
            clr_row     <= nxt_clr_row;
            clr_col     <= nxt_clr_col;
            scroll_pend <= nxt_scroll_pend;
            busy        <= (nxt_state != IDLE);
            ch_ready    <= (nxt_state == IDLE);
        end
    end

    // Next state; the registered write outputs describe the write of the coming cycle.
    always_comb begin
        nxt_state       = state;
        nxt_wr_en       = 1'b0;
        nxt_wr_addr     = wr_addr;
        nxt_wr_data     = wr_data;
        nxt_cur_row     = cur_row;
        nxt_cur_col     = cur_col;
        nxt_top_row     = top_row;
        nxt_clr_row     = clr_row;
        nxt_clr_col     = clr_col;
        nxt_scroll_pend = scroll_pend;
        newline_c       = 1'b0;

        unique case (state)
            INIT: begin
                // wr_en low only on the first cycle after reset: cell 0 not yet written.
                nxt_wr_en   = 1'b1;
                nxt_wr_data = BLANK;
                if (wr_en) begin
                    if (clr_col == COL_LAST) begin
                        if (clr_row == ROW_LAST) begin
                            nxt_state = IDLE;
                            nxt_wr_en = 1'b0;
                        end else begin
                            nxt_clr_row = clr_row + ROW_W'(1);
                            nxt_clr_col = '0;
                        end
                    end else begin
                        nxt_clr_col = clr_col + COL_W'(1);
                    end
                    nxt_wr_addr = {nxt_clr_row, nxt_clr_col};
                end
            end

            IDLE: begin
                if (accept_c) begin
                    if (printable_c) begin
                        nxt_state   = WRITE;
                        nxt_wr_en   = 1'b1;
                        nxt_wr_addr = {phys_row_c, cur_col};
                        nxt_wr_data = ch_data;
                        if (cur_col == COL_LAST) begin
                            newline_c = 1'b1;
                        end else begin
                            nxt_cur_col = cur_col + COL_W'(1);
                        end
                    end else if ((ch_data == LF) || (ch_data == CR)) begin
                        newline_c = 1'b1;
                    end else if (ch_data == BS) begin
                        if (cur_col != '0) begin
                            nxt_state   = WRITE;
                            nxt_wr_en   = 1'b1;
                            nxt_wr_addr = {phys_row_c, cur_col - COL_W'(1)};
                            nxt_wr_data = BLANK;
                            nxt_cur_col = cur_col - COL_W'(1);
                        end
                    end else if (ch_data == FF) begin
                        nxt_state       = INIT;
                        nxt_wr_en       = 1'b1;
                        nxt_wr_addr     = '0;
                        nxt_wr_data     = BLANK;
                        nxt_clr_row     = '0;
                        nxt_clr_col     = '0;
                        nxt_cur_row     = '0;
                        nxt_cur_col     = '0;
                        nxt_top_row     = '0;
                        nxt_scroll_pend = 1'b0;
                    end
                end
            end

            WRITE: begin
                if (scroll_pend) begin
                    nxt_state       = SCROLL;
                    nxt_scroll_pend = 1'b0;
                    nxt_wr_en       = 1'b1;
                    nxt_wr_addr     = {clr_row, COL_W'(0)};
                    nxt_wr_data     = BLANK;
                    nxt_clr_col     = '0;
                end else begin
                    nxt_state = IDLE;
                end
            end

            SCROLL: begin
                if (clr_col == COL_LAST) begin
                    nxt_state = IDLE;
                end else begin
                    nxt_clr_col = clr_col + COL_W'(1);
                    nxt_wr_en   = 1'b1;
                    nxt_wr_addr = {clr_row, nxt_clr_col};
                    nxt_wr_data = BLANK;
                end
            end

            default: nxt_state = INIT;
        endcase

        // Newline: step down, or at the bottom rotate top_row and blank the old top row.
        if (newline_c) begin
            nxt_cur_col = '0;
            if (cur_row != ROW_LAST) begin
                nxt_cur_row = cur_row + ROW_W'(1);
            end else begin
                nxt_top_row = row_inc(top_row);
                nxt_clr_row = top_row;
                nxt_clr_col = '0;
                if (nxt_state == WRITE) begin
                    nxt_scroll_pend = 1'b1;
                end else begin
                    nxt_state   = SCROLL;
                    nxt_wr_en   = 1'b1;
                    nxt_wr_addr = {top_row, COL_W'(0)};
                    nxt_wr_data = BLANK;
                end
            end
        end
    end

endmodule

// File: tb/tb_text_term_ctrl.sv
// Scoreboard bench for text_term_ctrl: a screen-level model predicts every RAM
// write (queued), the cursor/scroll position and how long ch_ready stays low.
module tb_text_term_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ch_valid = 1'b0;
    logic [7:0]  ch_data = 8'h00;
    logic        ch_ready, wr_en, busy;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic [4:0]  cur_row, top_row;
    logic [6:0]  cur_col;

    always #5 clk = ~clk;

    text_term_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .ch_valid (ch_valid),
        .ch_data  (ch_data),
        .ch_ready (ch_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cur_row  (cur_row),
        .cur_col  (cur_col),
        .top_row  (top_row),
        .busy     (busy)
    );

    int n_cmp = 0;
    int n_err = 0;
    int m_row = 0;
    int m_col = 0;
    int m_top = 0;
    int sb[$];
    int mon_exp;

    function automatic void chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Expected write encoded as (addr << 8) | data, addr = row*128 + col.
    function automatic void push_wr(input int row, input int col, input int data);
        sb.push_back(((row * 128) + col) * 256 + data);
    endfunction

    function automatic void model_nl(inout int nw);
        int old;
        m_col = 0;
        if (m_row < 29) begin
            m_row++;
        end else begin
            old   = m_top;
            m_top = (m_top + 1) % 30;
            for (int c = 0; c < 70; c++) push_wr(old, c, 32);
            nw += 70;
        end
    endfunction

    function automatic void model_init(output int nw);
        m_row = 0;
        m_col = 0;
        m_top = 0;
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 70; c++) push_wr(r, c, 32);
        nw = 2100;
    endfunction

    function automatic void model_byte(input int b, output int nw);
        nw = 0;
        if (b >= 32 && b <= 126) begin
            push_wr((m_top + m_row) % 30, m_col, b);
            nw = 1;
            m_col++;
            if (m_col == 70) model_nl(nw);
        end else if (b == 10 || b == 13) begin
            model_nl(nw);
        end else if (b == 8) begin
            if (m_col > 0) begin
                m_col--;
                push_wr((m_top + m_row) % 30, m_col, 32);
                nw = 1;
            end
        end else if (b == 12) begin
            model_init(nw);
        end
    endfunction

    function automatic int rand_byte();
        int k;
        int v;
        k = int'($urandom_range(0, 99));
        if (k < 55) return int'($urandom_range(32, 126));
        if (k < 70) return ($urandom_range(0, 1) == 1) ? 10 : 13;
        if (k < 82) return 8;
        v = int'($urandom_range(0, 255));
        if (v == 8 || v == 10 || v == 12 || v == 13 || (v >= 32 && v <= 126)) v = 127;
        return v;
    endfunction

    // Monitor: every write strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst && wr_en) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: got addr=0x%0h data=0x%0h required no write at %0t",
                         wr_addr, wr_data, $time);
            end else begin
                mon_exp = sb.pop_front();
                chk("write", int'({wr_addr, wr_data}), mon_exp);
            end
        end
    end

    // Called just after an active edge; counts low-ready cycles, then checks idle state.
    task automatic wait_idle(input int exp_n, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!ch_ready && n < 5000) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_ready_low_cycles"}, n, exp_n);
        chk({tag, "_cur_row"}, int'(cur_row), m_row);
        chk({tag, "_cur_col"}, int'(cur_col), m_col);
        chk({tag, "_top_row"}, int'(top_row), m_top);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_pending_writes"}, sb.size(), 0);
    endtask

    task automatic send(input int b, input string tag);
        int nw;
        model_byte(b, nw);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        ch_valid = 1'b1;
        ch_data  = 8'(b);
        @(posedge clk);
        #1;
        ch_valid = 1'b0;
        ch_data  = 8'($urandom);
        wait_idle(nw, tag);
    endtask

    initial begin
        int nw;
        int k;
        int g;

        repeat (3) @(negedge clk);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_wr_data", int'(wr_data), 32);
        chk("rst_busy", int'(busy), 1);
        chk("rst_ch_ready", int'(ch_ready), 0);
        chk("rst_cursor", int'({cur_row, cur_col}), 0);
        chk("rst_top_row", int'(top_row), 0);

        model_init(nw);
        rst = 1'b1;
        wait_idle(nw, "init");

        send(8'h41, "char_A");
        for (int i = 1; i < 70; i++) send(int'($urandom_range(32, 126)), "row0_fill");
        send(8, "bs_col0");
        repeat (4) send(int'($urandom_range(32, 126)), "pre_bs");
        send(8, "bs_mid");

        repeat (30) send(10, "lf_to_bottom");
        repeat (5) send(int'($urandom_range(32, 126)), "bottom_chars");
        send(10, "bottom_lf_scroll");
        for (int i = 0; i < 70; i++) send(int'($urandom_range(32, 126)), "chained_fill");

        for (int i = 0; i < 600; i++) send(rand_byte(), "random");
        send(12, "form_feed");
        for (int i = 0; i < 100; i++) send(rand_byte(), "random2");

        // Reset asserted in the middle of a scroll.
        repeat (30) send(13, "cr_to_bottom");
        model_byte(10, nw);
        ch_valid = 1'b1;
        ch_data  = 8'h0A;
        @(posedge clk);
        #1;
        ch_valid = 1'b0;
        k = 0;
        g = 0;
        while (k < 20 && g < 500) begin
            @(negedge clk);
            g++;
            if (wr_en) k++;
        end
        chk("scroll_writes_before_rst", k, 20);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_wr_en", int'(wr_en), 0);
        chk("async_rst_busy", int'(busy), 1);
        chk("async_rst_ch_ready", int'(ch_ready), 0);
        chk("async_rst_top_row", int'(top_row), 0);
        sb.delete();
        model_init(nw);
        @(negedge clk);
        rst = 1'b1;
        wait_idle(nw, "reinit");
        send(8'h5A, "post_reset_char");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
